// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared CP0 command, exception-info and exception-flag types for the commit controller
package exc_ctrl_pkg;
   typedef enum logic [2:0] {CP0_NONE, CP0_MTC0, CP0_EXC, CP0_BADVA, CP0_ERET, CP0_TLB} cp0_op_t;
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef struct packed {
      logic [31:0] epc;
      logic        cause_bd;
      logic [4:0]  cause_exccode;
      logic [31:0] badvaddr;
   } exc_info_t;
   typedef struct packed {
      logic adel_if, tlbr_if, tlbi_if, ri, ov, sys, bp, adel_d, ades_d, tlbr_d, tlbi_d, tlbmod, is_store;
   } exc_flags_t;
   localparam logic [4:0] EXC_INT = 5'h00, EXC_MOD = 5'h01, EXC_TLBL = 5'h02, EXC_TLBS = 5'h03,
                          EXC_ADEL = 5'h04, EXC_ADES = 5'h05, EXC_SYS = 5'h08, EXC_BP = 5'h09,
                          EXC_RI = 5'h0A, EXC_OV = 5'h0C;
   localparam logic [31:0] VEC_REFILL = 32'h000, VEC_GENERAL = 32'h180, VEC_BEV_OFS = 32'h200;
   // is_store only qualifies the data TLB code, so it is not itself an exception
   function automatic logic any_exc(exc_flags_t f);
      return |f[12:1];
   endfunction
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: CP0 register-file write command bus and its read-back status
interface exc_ctrl_if;
   import exc_ctrl_pkg::*;
   logic        wen;
   cp0_op_t     wtype;
   logic [4:0]  waddr;
   logic [2:0]  wsel;
   logic [31:0] wdata;
   exc_info_t   exc_info;
   logic [31:0] status, cause, epc;
   logic        rready;
   modport master (output wen, wtype, waddr, wsel, wdata, exc_info, input status, cause, epc, rready);
   modport slave (input wen, wtype, waddr, wsel, wdata, exc_info, output status, cause, epc, rready);
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// exc_prio_enc: picks the highest-priority pending exception and its ExcCode/CP0 command
module exc_prio_enc import exc_ctrl_pkg::*; (
   input  logic       int_pend,
   input  exc_flags_t exc,
   output logic       hit,
   output logic [4:0] exccode,
   output cp0_op_t    wtype,
   output logic       use_pc_badva,
   output logic       refill
);
   logic fetch_tlb, data_ad, data_tlb, mid;
   always_comb begin
      fetch_tlb = exc.tlbr_if | exc.tlbi_if;
      data_ad = exc.adel_d | exc.ades_d;
      data_tlb = exc.tlbr_d | exc.tlbi_d;
      mid = exc.ri | exc.ov | exc.sys | exc.bp;
      hit = int_pend | any_exc(exc);
      exccode = int_pend ? EXC_INT : exc.adel_if ? EXC_ADEL : fetch_tlb ? EXC_TLBL : exc.ri ? EXC_RI :
                exc.ov ? EXC_OV : exc.sys ? EXC_SYS : exc.bp ? EXC_BP : exc.adel_d ? EXC_ADEL :
                exc.ades_d ? EXC_ADES : data_tlb ? (exc.is_store ? EXC_TLBS : EXC_TLBL) :
                exc.tlbmod ? EXC_MOD : EXC_INT;
      wtype = int_pend ? CP0_EXC : exc.adel_if ? CP0_BADVA : fetch_tlb ? CP0_TLB : mid ? CP0_EXC :
              data_ad ? CP0_BADVA : (data_tlb | exc.tlbmod) ? CP0_TLB : CP0_NONE;
      use_pc_badva = !int_pend && (exc.adel_if | fetch_tlb);
      // only a refill (not invalid) that actually wins selection uses the refill vector
      refill = !int_pend && !exc.adel_if && (fetch_tlb ? exc.tlbr_if : !mid && !data_ad && data_tlb && exc.tlbr_d);
   end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt commit controller; sole issuer of CP0 write commands
module exc_ctrl import exc_ctrl_pkg::*; #(
   parameter logic [31:0] RESET_VEC  = 32'hBFC0_0000,
   parameter logic [31:0] KSEG0_BASE = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m_valid,
   input  logic             m_stall,
   input  logic [31:0]      m_pc,
   input  logic             m_bd,
   input  exc_flags_t       m_exc,
   input  logic [31:0]      m_badvaddr,
   input  logic             m_is_eret,
   input  logic             m_is_mtc0,
   input  logic [4:0]       m_cp0_waddr,
   input  logic [2:0]       m_cp0_wsel,
   input  logic [31:0]      m_cp0_wdata,
   exc_ctrl_if.master       cp0,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             stall_req
);
   state_t      state, state_nx;
   logic        int_pend, hit, use_pc_badva, refill, commit, exc_go, eret_go, mtc0_go;
   logic [4:0]  exccode;
   cp0_op_t     exc_wtype;
   logic [31:0] base;
   exc_info_t   info;
   logic        unused;
   assign unused = ^{cp0.status[31:23], cp0.status[21:16], cp0.status[7:2], cp0.cause[31:16], cp0.cause[7:0]};
   // interrupts only look at CP0 once its outputs reflect the last write
   assign int_pend = state == S_IDLE && cp0.rready && |(cp0.cause[15:8] & cp0.status[15:8]) &&
                     cp0.status[0] && !cp0.status[1];
   exc_prio_enc u_prio (
      .int_pend(int_pend), .exc(m_exc), .hit(hit), .exccode(exccode),
      .wtype(exc_wtype), .use_pc_badva(use_pc_badva), .refill(refill)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = cp0.wen ? S_WAIT : (state == S_WAIT && cp0.rready) ? S_IDLE : state;
   end
   always_comb begin
      stall_req = rst_n && m_valid && (state == S_WAIT ? (m_is_eret | m_is_mtc0 | any_exc(m_exc)) :
                                       (m_is_eret && !cp0.rready && !any_exc(m_exc)));
      commit = rst_n && m_valid && !m_stall && !stall_req;
      exc_go = commit && hit;
      eret_go = commit && !hit && m_is_eret;
      mtc0_go = commit && !hit && !m_is_eret && m_is_mtc0;
      base = cp0.status[22] ? RESET_VEC + VEC_BEV_OFS : KSEG0_BASE;
      info = '{epc: m_bd ? m_pc - 32'd4 : m_pc, cause_bd: m_bd, cause_exccode: exccode,
               badvaddr: use_pc_badva ? m_pc : m_badvaddr};
      cp0.wen = exc_go | eret_go | mtc0_go;
      cp0.wtype = exc_go ? exc_wtype : eret_go ? CP0_ERET : mtc0_go ? CP0_MTC0 : CP0_NONE;
      cp0.waddr = mtc0_go ? m_cp0_waddr : '0;
      cp0.wsel = mtc0_go ? m_cp0_wsel : '0;
      cp0.wdata = mtc0_go ? m_cp0_wdata : '0;
      cp0.exc_info = exc_go ? info : '0;
      flush = exc_go | eret_go;
      redirect_valid = exc_go | eret_go;
      redirect_pc = exc_go ? base + ((refill && !cp0.status[1]) ? VEC_REFILL : VEC_GENERAL) :
                    eret_go ? cp0.epc : '0;
   end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed test-plan steps plus random traffic checked against a rule-level reference model
module tb_exc_ctrl;
   import exc_ctrl_pkg::*;
   logic        clk = 0, rst_n = 0;
   logic        m_valid, m_stall, m_bd, m_is_eret, m_is_mtc0;
   logic [31:0] m_pc, m_badvaddr, m_cp0_wdata;
   exc_flags_t  m_exc;
   logic [4:0]  m_cp0_waddr;
   logic [2:0]  m_cp0_wsel;
   logic        flush, redirect_valid, stall_req;
   logic [31:0] redirect_pc;
   int          checks = 0, errors = 0;
   bit          mwait = 0, prev_wen = 0;

   typedef struct packed {
      logic        wen;
      logic [2:0]  wtype;
      logic [4:0]  waddr;
      logic [2:0]  wsel;
      logic [31:0] wdata;
      exc_info_t   info;
      logic        flush, rv;
      logic [31:0] rpc;
      logic        stall;
   } exp_t;
   typedef struct {bit act; logic [4:0] code; cp0_op_t ty; bit fetch; bit refill;} row_t;

   exc_ctrl_if cp0();
   exc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_stall(m_stall), .m_pc(m_pc), .m_bd(m_bd),
      .m_exc(m_exc), .m_badvaddr(m_badvaddr), .m_is_eret(m_is_eret), .m_is_mtc0(m_is_mtc0),
      .m_cp0_waddr(m_cp0_waddr), .m_cp0_wsel(m_cp0_wsel), .m_cp0_wdata(m_cp0_wdata), .cp0(cp0),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   // reference: the exception table walked top-down, first active row wins
   function automatic exp_t model();
      exp_t e;
      row_t rows[10];
      bit anyx, intp;
      logic [31:0] base;
      e = '0;
      if (!rst_n) return e;
      anyx = m_exc.adel_if || m_exc.tlbr_if || m_exc.tlbi_if || m_exc.ri || m_exc.ov || m_exc.sys ||
             m_exc.bp || m_exc.adel_d || m_exc.ades_d || m_exc.tlbr_d || m_exc.tlbi_d || m_exc.tlbmod;
      intp = !mwait && cp0.rready && ((cp0.cause[15:8] & cp0.status[15:8]) != 0) && cp0.status[0] && !cp0.status[1];
      e.stall = m_valid && (mwait ? (m_is_eret || m_is_mtc0 || anyx) : (m_is_eret && !cp0.rready && !anyx));
      if (!m_valid || m_stall || e.stall) return e;
      rows[0] = '{intp, 5'h00, CP0_EXC, 0, 0};
      rows[1] = '{m_exc.adel_if, 5'h04, CP0_BADVA, 1, 0};
      rows[2] = '{m_exc.tlbr_if || m_exc.tlbi_if, 5'h02, CP0_TLB, 1, m_exc.tlbr_if};
      rows[3] = '{m_exc.ri, 5'h0A, CP0_EXC, 0, 0};
      rows[4] = '{m_exc.ov, 5'h0C, CP0_EXC, 0, 0};
      rows[5] = '{m_exc.sys, 5'h08, CP0_EXC, 0, 0};
      rows[6] = '{m_exc.bp, 5'h09, CP0_EXC, 0, 0};
      rows[7] = '{m_exc.adel_d || m_exc.ades_d, m_exc.adel_d ? 5'h04 : 5'h05, CP0_BADVA, 0, 0};
      rows[8] = '{m_exc.tlbr_d || m_exc.tlbi_d, m_exc.is_store ? 5'h03 : 5'h02, CP0_TLB, 0, m_exc.tlbr_d};
      rows[9] = '{m_exc.tlbmod, 5'h01, CP0_TLB, 0, 0};
      base = cp0.status[22] ? 32'hBFC0_0200 : 32'h8000_0000;
      foreach (rows[i]) if (rows[i].act) begin
         e.wen = 1; e.wtype = rows[i].ty; e.flush = 1; e.rv = 1;
         e.info = '{m_bd ? m_pc - 4 : m_pc, m_bd, rows[i].code, rows[i].fetch ? m_pc : m_badvaddr};
         e.rpc = base + ((rows[i].refill && !cp0.status[1]) ? 32'h0 : 32'h180);
         return e;
      end
      if (m_is_eret) begin
         e.wen = 1; e.wtype = CP0_ERET; e.flush = 1; e.rv = 1; e.rpc = cp0.epc;
      end else if (m_is_mtc0) begin
         e.wen = 1; e.wtype = CP0_MTC0; e.waddr = m_cp0_waddr; e.wsel = m_cp0_wsel; e.wdata = m_cp0_wdata;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_now(input string tag, output exp_t e);
      #1;
      e = model();
      chk({tag, ":wen"}, cp0.wen, e.wen);
      chk({tag, ":wtype"}, cp0.wtype, e.wtype);
      chk({tag, ":mtc0"}, {cp0.waddr, cp0.wsel, cp0.wdata}, {e.waddr, e.wsel, e.wdata});
      chk({tag, ":epc"}, cp0.exc_info.epc, e.info.epc);
      chk({tag, ":bd_code"}, {cp0.exc_info.cause_bd, cp0.exc_info.cause_exccode}, {e.info.cause_bd, e.info.cause_exccode});
      if (e.wtype == CP0_BADVA || e.wtype == CP0_TLB) chk({tag, ":badva"}, cp0.exc_info.badvaddr, e.info.badvaddr);
      chk({tag, ":flush_rv"}, {flush, redirect_valid}, {e.flush, e.rv});
      chk({tag, ":rpc"}, redirect_pc, e.rpc);
      chk({tag, ":stall"}, stall_req, e.stall);
      chk({tag, ":b2b"}, cp0.wen & prev_wen, 0);
      prev_wen = cp0.wen;
   endtask

   task automatic step(input string tag);
      exp_t e;
      check_now(tag, e);
      @(posedge clk);
      if (rst_n) mwait = e.wen ? 1'b1 : (mwait && cp0.rready) ? 1'b0 : mwait;
      else prev_wen = 0;
      #1;
   endtask

   task automatic idle_in();
      m_valid = 0; m_stall = 0; m_pc = 0; m_bd = 0; m_exc = '0; m_badvaddr = 0;
      m_is_eret = 0; m_is_mtc0 = 0; m_cp0_waddr = 0; m_cp0_wsel = 0; m_cp0_wdata = 0;
      cp0.status = 0; cp0.cause = 0; cp0.epc = 0; cp0.rready = 1;
   endtask

   initial begin
      idle_in();
      step("reset");
      rst_n = 1;
      // syscall, BEV=0
      m_valid = 1; m_pc = 32'h8000_1000; m_exc.sys = 1;
      #1; chk("sys:rpc_const", redirect_pc, 32'h8000_0180);
      chk("sys:code_const", cp0.exc_info.cause_exccode, 5'h08);
      step("sys");
      cp0.rready = 0;
      step("sys_wait_stall");
      cp0.rready = 1; m_exc = '0;
      step("wait_exit");
      // AdES in a delay slot
      m_pc = 32'h8000_2004; m_bd = 1; m_badvaddr = 32'h1003; m_exc.ades_d = 1;
      #1; chk("ades:epc_const", cp0.exc_info.epc, 32'h8000_2000);
      chk("ades:wtype_const", cp0.wtype, CP0_BADVA);
      step("ades");
      m_valid = 0; m_exc = '0; m_bd = 0;
      step("gap0");
      // data TLB refill on store, BEV=1, EXL=0 then EXL=1
      m_valid = 1; m_pc = 32'h8000_2100; m_badvaddr = 32'h0040_0010; m_exc.tlbr_d = 1; m_exc.is_store = 1;
      cp0.status = 32'h0040_0000;
      #1; chk("tlbs:rpc_const", redirect_pc, 32'hBFC0_0200);
      step("tlbs_refill");
      m_valid = 0;
      step("gap1");
      m_valid = 1; cp0.status = 32'h0040_0002;
      #1; chk("tlbs_exl:rpc_const", redirect_pc, 32'hBFC0_0380);
      step("tlbs_exl");
      m_valid = 0; m_exc = '0; cp0.status = 0;
      step("gap2");
      // MTC0 then ERET while CP0 outputs refresh
      m_valid = 1; m_is_mtc0 = 1; m_cp0_waddr = 5'd14; m_cp0_wsel = 0; m_cp0_wdata = 32'h8000_3000; cp0.rready = 0;
      step("mtc0");
      m_is_mtc0 = 0; m_is_eret = 1; cp0.epc = 32'h8000_3000;
      #1; chk("eret:stall1_const", stall_req, 1'b1);
      step("eret_stall1");
      cp0.rready = 1;
      #1; chk("eret:stall2_const", stall_req, 1'b1);
      step("eret_stall2");
      #1; chk("eret:rpc_const", redirect_pc, 32'h8000_3000);
      step("eret");
      m_valid = 0; m_is_eret = 0;
      step("gap3");
      // interrupt on a plain instruction, then masked in WAIT and with EXL=1
      m_valid = 1; m_pc = 32'h8000_4000; cp0.cause = 32'h0000_0400; cp0.status = 32'h0000_0401;
      #1; chk("int:code_const", {cp0.wen, cp0.exc_info.cause_exccode}, {1'b1, 5'h00});
      step("int");
      step("int_in_wait");
      cp0.status = 32'h0000_0403;
      step("int_exl");
      idle_in();
      step("gap4");
      repeat (400) begin
         m_valid = ($urandom % 4) != 0; m_stall = ($urandom % 5) == 0;
         m_pc = {$urandom, 2'b00} ; m_bd = $urandom; m_badvaddr = $urandom;
         m_exc = '0;
         for (int b = 1; b < 13; b++) m_exc[b] = ($urandom % 20) == 0;
         m_exc.is_store = $urandom;
         m_is_eret = ($urandom % 6) == 0; m_is_mtc0 = ($urandom % 6) == 0;
         m_cp0_waddr = $urandom; m_cp0_wsel = $urandom; m_cp0_wdata = $urandom;
         cp0.status = $urandom & 32'h0040_FF03; cp0.cause = $urandom & 32'h0000_FF00;
         cp0.epc = $urandom; cp0.rready = ($urandom % 3) != 0;
         step("rand");
      end
      // async reset while in WAIT with a stalled MTC0
      idle_in();
      cp0.rready = 0; m_valid = 1; m_exc.sys = 1;
      step("pre_rst_sys");
      m_exc = '0; m_is_mtc0 = 1; m_stall = 1;
      #1; chk("pre_rst:stall_const", stall_req, 1'b1);
      rst_n = 0; mwait = 0;
      #1; chk("rst:outs_const", {cp0.wen, cp0.wtype, flush, redirect_valid, redirect_pc, stall_req}, 0);
      begin
         exp_t e;
         check_now("rst_async", e);
      end
      rst_n = 1;
      #1; chk("post_rst:stall_const", stall_req, 1'b0);
      step("post_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
